de_pipe_stage: RTL and testbench

Parametrised decode-to-execute pipeline register for the five-stage MIPS core. It latches the decoded instruction bundle from D on each clock edge and presents it to E. It adds hold (downstream stall), bubble (hazard stall) and flush (taken-branch kill) control. It also tracks a per-instruction valid bit and a self-decrementing Tnew counter, so the hazard unit can forward from E without recomputing timing.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/tnew_counter.sv | 44 ++++
 rtl/de_pipe_stage.sv | 172 +++++++++++++++++
 tb/tb_de_pipe_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: nop encoding, register-field offsets,
// the stage action encoding and the saturating Tnew decrement.
package pipe_pkg;

  localparam logic [31:0] NOP_IR = 32'h0000_0000;

  // Bit offsets of the rs / rt register fields inside a MIPS instruction word.
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_FLUSH  = 2'd3
  } stage_act_e;

  // Counts down towards zero and sticks there; callers cast to their own width.
  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

endpackage

// File: rtl/tnew_counter.sv
// Remaining-Tnew counter: loads a new value, otherwise counts down on request
// and saturates at zero. Shared by the E- and M-stage pipeline registers.
module tnew_counter
  import pipe_pkg::*;
#(
  parameter int TNEW_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              dec_i,
  input  logic [TNEW_W-1:0] load_val_i,
  output logic [TNEW_W-1:0] cnt_o,
  output logic              zero_o
);

  logic [TNEW_W-1:0] cnt_q;
  logic [TNEW_W-1:0] cnt_d;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = TNEW_W'(sat_dec(32'(cnt_q)));
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/de_pipe_stage.sv
// Decode-to-execute pipeline register with hold / bubble / flush control,
// a per-instruction valid bit and a self-decrementing Tnew for forwarding.
module de_pipe_stage
  import pipe_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          REG_W     = 5,
  parameter int          TNEW_W    = 4,
  parameter logic [31:0] BUBBLE_IR = pipe_pkg::NOP_IR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              bubble,
  input  logic              flush,
  input  logic              d_valid,
  input  logic [DATA_W-1:0] d_ir,
  input  logic [DATA_W-1:0] d_pc,
  input  logic [DATA_W-1:0] d_rs,
  input  logic [DATA_W-1:0] d_rt,
  input  logic [DATA_W-1:0] d_imm,
  input  logic [DATA_W-1:0] d_npc,
  input  logic              d_branch_op,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic [REG_W-1:0]  d_writereg,
  output logic              e_valid,
  output logic [DATA_W-1:0] e_ir,
  output logic [DATA_W-1:0] e_pc,
  output logic [DATA_W-1:0] e_rs,
  output logic [DATA_W-1:0] e_rt,
  output logic [DATA_W-1:0] e_imm,
  output logic [DATA_W-1:0] e_npc,
  output logic [DATA_W-1:0] e_pc8,
  output logic              e_branch_op,
  output logic [REG_W-1:0]  e_rs_a,
  output logic [REG_W-1:0]  e_rt_a,
  output logic [TNEW_W-1:0] e_tnew,
  output logic [REG_W-1:0]  e_writereg,
  output logic              e_fwd_ok
);

  localparam logic [DATA_W-1:0] BUBBLE_WORD = DATA_W'(BUBBLE_IR);

  stage_act_e act;

  logic              valid_q,  valid_d;
  logic [DATA_W-1:0] ir_q,     ir_d;
  logic [DATA_W-1:0] pc_q,     pc_d;
  logic [DATA_W-1:0] rs_q,     rs_d;
  logic [DATA_W-1:0] rt_q,     rt_d;
  logic [DATA_W-1:0] imm_q,    imm_d;
  logic [DATA_W-1:0] npc_q,    npc_d;
  logic              br_q,     br_d;
  logic [REG_W-1:0]  wreg_q,   wreg_d;

  logic [TNEW_W-1:0] tnew_cnt;
  logic              tnew_zero;

  // A non-valid D slot is treated exactly like a requested bubble.
  always_comb begin
    if (flush) begin
      act = ACT_FLUSH;
    end else if (hold) begin
      act = ACT_HOLD;
    end else if (bubble || !d_valid) begin
      act = ACT_BUBBLE;
    end else begin
      act = ACT_LOAD;
    end
  end

  always_comb begin
    valid_d = valid_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    imm_d   = imm_q;
    npc_d   = npc_q;
    br_d    = br_q;
    wreg_d  = wreg_q;
    unique case (act)
      ACT_FLUSH: begin
        valid_d = 1'b0;
        ir_d    = BUBBLE_WORD;
        pc_d    = '0;
        rs_d    = '0;
        rt_d    = '0;
        imm_d   = '0;
        npc_d   = '0;
        br_d    = 1'b0;
        wreg_d  = '0;
      end
      ACT_BUBBLE: begin
        // The D-side PC survives so a later exception can still be attributed.
        valid_d = 1'b0;
        ir_d    = BUBBLE_WORD;
        pc_d    = d_pc;
        rs_d    = '0;
        rt_d    = '0;
        imm_d   = '0;
        npc_d   = d_npc;
        br_d    = 1'b0;
        wreg_d  = '0;
      end
      ACT_LOAD: begin
        valid_d = 1'b1;
        ir_d    = d_ir;
        pc_d    = d_pc;
        rs_d    = d_rs;
        rt_d    = d_rt;
        imm_d   = d_imm;
        npc_d   = d_npc;
        br_d    = d_branch_op;
        wreg_d  = d_writereg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ir_q    <= BUBBLE_WORD;
      pc_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
      npc_q   <= '0;
      br_q    <= 1'b0;
      wreg_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      imm_q   <= imm_d;
      npc_q   <= npc_d;
      br_q    <= br_d;
      wreg_q  <= wreg_d;
    end
  end

  tnew_counter #(
    .TNEW_W (TNEW_W)
  ) u_tnew (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (act != ACT_HOLD),
    .dec_i      (act == ACT_HOLD),
    .load_val_i ((act == ACT_LOAD) ? d_tnew : '0),
    .cnt_o      (tnew_cnt),
    .zero_o     (tnew_zero)
  );

  assign e_valid     = valid_q;
  assign e_ir        = ir_q;
  assign e_pc        = pc_q;
  assign e_rs        = rs_q;
  assign e_rt        = rt_q;
  assign e_imm       = imm_q;
  assign e_npc       = npc_q;
  assign e_branch_op = br_q;
  assign e_tnew      = tnew_cnt;
  assign e_pc8       = pc_q + DATA_W'(8);
  assign e_rs_a      = ir_q[RS_LSB +: REG_W];
  assign e_rt_a      = ir_q[RT_LSB +: REG_W];
  assign e_writereg  = valid_q ? wreg_q : '0;
  assign e_fwd_ok    = valid_q && (wreg_q != '0) && tnew_zero;

endmodule

// File: tb/tb_de_pipe_stage.sv
// Self-checking bench for de_pipe_stage: table-driven vectors through a
// scoreboard queue, plus a hand-written asynchronous-reset sequence.
module tb_de_pipe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold, bubble, flush, d_valid;
  logic [31:0] d_ir, d_pc, d_rs, d_rt, d_imm, d_npc;
  logic        d_branch_op;
  logic [3:0]  d_tnew;
  logic [4:0]  d_writereg;
  logic        e_valid;
  logic [31:0] e_ir, e_pc, e_rs, e_rt, e_imm, e_npc, e_pc8;
  logic        e_branch_op;
  logic [4:0]  e_rs_a, e_rt_a, e_writereg;
  logic [3:0]  e_tnew;
  logic        e_fwd_ok;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        hold, bubble, flush, valid;
    logic [31:0] ir, pc, npc, rs, rt, imm;
    logic        br;
    logic [3:0]  tnew;
    logic [4:0]  wr;
  } stim_t;

  typedef struct {
    logic        valid;
    logic [31:0] ir, pc, npc, rs, rt, imm, pc8;
    logic [4:0]  rs_a, rt_a;
    logic [3:0]  tnew;
    logic [4:0]  wr;
    logic        br, fwd;
  } exp_t;

  exp_t sb_q[$];

  de_pipe_stage dut (
    .clk         (clk),
    .reset       (reset),
    .hold        (hold),
    .bubble      (bubble),
    .flush       (flush),
    .d_valid     (d_valid),
    .d_ir        (d_ir),
    .d_pc        (d_pc),
    .d_rs        (d_rs),
    .d_rt        (d_rt),
    .d_imm       (d_imm),
    .d_npc       (d_npc),
    .d_branch_op (d_branch_op),
    .d_tnew      (d_tnew),
    .d_writereg  (d_writereg),
    .e_valid     (e_valid),
    .e_ir        (e_ir),
    .e_pc        (e_pc),
    .e_rs        (e_rs),
    .e_rt        (e_rt),
    .e_imm       (e_imm),
    .e_npc       (e_npc),
    .e_pc8       (e_pc8),
    .e_branch_op (e_branch_op),
    .e_rs_a      (e_rs_a),
    .e_rt_a      (e_rt_a),
    .e_tnew      (e_tnew),
    .e_writereg  (e_writereg),
    .e_fwd_ok    (e_fwd_ok)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk_s(logic h, logic b, logic f, logic v,
                                 logic [31:0] ir, logic [31:0] pc, logic [31:0] npc,
                                 logic [31:0] rs, logic [31:0] rt, logic [31:0] imm,
                                 logic br, logic [3:0] tnew, logic [4:0] wr);
    stim_t s;
    s.hold = h; s.bubble = b; s.flush = f; s.valid = v;
    s.ir = ir; s.pc = pc; s.npc = npc; s.rs = rs; s.rt = rt; s.imm = imm;
    s.br = br; s.tnew = tnew; s.wr = wr;
    return s;
  endfunction

  function automatic exp_t mk_e(logic v, logic [31:0] ir, logic [31:0] pc, logic [31:0] npc,
                                logic [31:0] rs, logic [31:0] rt, logic [31:0] imm,
                                logic [31:0] pc8, logic [4:0] rs_a, logic [4:0] rt_a,
                                logic [3:0] tnew, logic [4:0] wr, logic br, logic fwd);
    exp_t e;
    e.valid = v; e.ir = ir; e.pc = pc; e.npc = npc; e.rs = rs; e.rt = rt; e.imm = imm;
    e.pc8 = pc8; e.rs_a = rs_a; e.rt_a = rt_a; e.tnew = tnew; e.wr = wr; e.br = br; e.fwd = fwd;
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic compare(string tag, exp_t e);
    check({tag, ".e_valid"},     32'(e_valid),     32'(e.valid));
    check({tag, ".e_ir"},        e_ir,             e.ir);
    check({tag, ".e_pc"},        e_pc,             e.pc);
    check({tag, ".e_npc"},       e_npc,            e.npc);
    check({tag, ".e_rs"},        e_rs,             e.rs);
    check({tag, ".e_rt"},        e_rt,             e.rt);
    check({tag, ".e_imm"},       e_imm,            e.imm);
    check({tag, ".e_pc8"},       e_pc8,            e.pc8);
    check({tag, ".e_rs_a"},      32'(e_rs_a),      32'(e.rs_a));
    check({tag, ".e_rt_a"},      32'(e_rt_a),      32'(e.rt_a));
    check({tag, ".e_tnew"},      32'(e_tnew),      32'(e.tnew));
    check({tag, ".e_writereg"},  32'(e_writereg),  32'(e.wr));
    check({tag, ".e_branch_op"}, 32'(e_branch_op), 32'(e.br));
    check({tag, ".e_fwd_ok"},    32'(e_fwd_ok),    32'(e.fwd));
  endtask

  task automatic drive(stim_t s);
    hold = s.hold; bubble = s.bubble; flush = s.flush; d_valid = s.valid;
    d_ir = s.ir; d_pc = s.pc; d_npc = s.npc; d_rs = s.rs; d_rt = s.rt; d_imm = s.imm;
    d_branch_op = s.br; d_tnew = s.tnew; d_writereg = s.wr;
  endtask

  // Waits for the edge that consumes the driven inputs and scores the oldest expectation.
  task automatic score_edge(string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got e_pc 0x%08h, expected an entry", tag, e_pc);
    end else begin
      e = sb_q.pop_front();
      compare(tag, e);
    end
  endtask

  task automatic apply(string tag, stim_t s, exp_t e);
    @(negedge clk);
    drive(s);
    sb_q.push_back(e);
    score_edge(tag);
  endtask

  stim_t vs[];
  exp_t  ve[];
  stim_t z_s;
  stim_t hold_s;

  initial begin
    z_s    = mk_s(0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 4'd0, 5'd0);
    hold_s = mk_s(1,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 4'd0, 5'd0);
    vs = new[15];
    ve = new[15];
    // idle load with all-zero inputs
    vs[0]  = z_s;
    ve[0]  = mk_e(0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8, 5'd0, 5'd0, 4'd0, 5'd0, 0, 0);
    vs[1]  = mk_s(0,0,0,1, 32'h0109_5021, 32'h3000, 32'h3004, 32'h11, 32'h22, 32'h5021, 1, 4'd1, 5'd10);
    ve[1]  = mk_e(1, 32'h0109_5021, 32'h3000, 32'h3004, 32'h11, 32'h22, 32'h5021, 32'h3008, 5'd8, 5'd9, 4'd1, 5'd10, 1, 0);
    // hold ignores new D data and counts Tnew down
    vs[2]  = mk_s(1,0,0,1, 32'hFFFF_FFFF, 32'h5000, 32'h5004, 32'h99, 32'h99, 32'h99, 0, 4'd7, 5'd31);
    ve[2]  = mk_e(1, 32'h0109_5021, 32'h3000, 32'h3004, 32'h11, 32'h22, 32'h5021, 32'h3008, 5'd8, 5'd9, 4'd0, 5'd10, 1, 1);
    vs[3]  = mk_s(0,0,0,1, 32'h00A4_3020, 32'h3004, 32'h3008, 32'h33, 32'h44, 32'h3020, 0, 4'd2, 5'd6);
    ve[3]  = mk_e(1, 32'h00A4_3020, 32'h3004, 32'h3008, 32'h33, 32'h44, 32'h3020, 32'h300C, 5'd5, 5'd4, 4'd2, 5'd6, 0, 0);
    vs[4]  = hold_s;
    ve[4]  = mk_e(1, 32'h00A4_3020, 32'h3004, 32'h3008, 32'h33, 32'h44, 32'h3020, 32'h300C, 5'd5, 5'd4, 4'd1, 5'd6, 0, 0);
    vs[5]  = hold_s;
    ve[5]  = mk_e(1, 32'h00A4_3020, 32'h3004, 32'h3008, 32'h33, 32'h44, 32'h3020, 32'h300C, 5'd5, 5'd4, 4'd0, 5'd6, 0, 1);
    vs[6]  = hold_s;
    ve[6]  = mk_e(1, 32'h00A4_3020, 32'h3004, 32'h3008, 32'h33, 32'h44, 32'h3020, 32'h300C, 5'd5, 5'd4, 4'd0, 5'd6, 0, 1);
    // bubble keeps the D-side PC
    vs[7]  = mk_s(0,1,0,1, 32'h0109_5021, 32'h3010, 32'h3014, 32'h55, 32'h66, 32'h77, 1, 4'd3, 5'd9);
    ve[7]  = mk_e(0, 32'h0, 32'h3010, 32'h3014, 32'h0, 32'h0, 32'h0, 32'h3018, 5'd0, 5'd0, 4'd0, 5'd0, 0, 0);
    vs[8]  = mk_s(0,0,0,1, 32'h0109_5021, 32'h3020, 32'h3024, 32'h11, 32'h22, 32'h5021, 0, 4'd3, 5'd10);
    ve[8]  = mk_e(1, 32'h0109_5021, 32'h3020, 32'h3024, 32'h11, 32'h22, 32'h5021, 32'h3028, 5'd8, 5'd9, 4'd3, 5'd10, 0, 0);
    // flush wins over hold
    vs[9]  = mk_s(1,0,1,1, 32'h0109_5021, 32'h3030, 32'h3034, 32'h11, 32'h22, 32'h5021, 1, 4'd2, 5'd10);
    ve[9]  = mk_e(0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8, 5'd0, 5'd0, 4'd0, 5'd0, 0, 0);
    // d_valid=0 turns a normal load into a bubble with PC kept
    vs[10] = mk_s(0,0,0,0, 32'h0109_5021, 32'h3030, 32'h3034, 32'h11, 32'h22, 32'h5021, 1, 4'd5, 5'd7);
    ve[10] = mk_e(0, 32'h0, 32'h3030, 32'h3034, 32'h0, 32'h0, 32'h0, 32'h3038, 5'd0, 5'd0, 4'd0, 5'd0, 0, 0);
    // d_tnew=0: forwardable right after the load
    vs[11] = mk_s(0,0,0,1, 32'h0062_1820, 32'h3040, 32'h3044, 32'h1, 32'h2, 32'h1820, 0, 4'd0, 5'd3);
    ve[11] = mk_e(1, 32'h0062_1820, 32'h3040, 32'h3044, 32'h1, 32'h2, 32'h1820, 32'h3048, 5'd3, 5'd2, 4'd0, 5'd3, 0, 1);
    // writereg 0 never forwards
    vs[12] = mk_s(0,0,0,1, 32'h0062_1820, 32'h3050, 32'h3054, 32'h1, 32'h2, 32'h1820, 0, 4'd0, 5'd0);
    ve[12] = mk_e(1, 32'h0062_1820, 32'h3050, 32'h3054, 32'h1, 32'h2, 32'h1820, 32'h3058, 5'd3, 5'd2, 4'd0, 5'd0, 0, 0);
    // PC+8 wraps; maximum Tnew
    vs[13] = mk_s(0,0,0,1, 32'h0109_5021, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hA, 32'hB, 32'hC, 1, 4'd15, 5'd31);
    ve[13] = mk_e(1, 32'h0109_5021, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hA, 32'hB, 32'hC, 32'h0, 5'd8, 5'd9, 4'd15, 5'd31, 1, 0);
    // hold beats bubble
    vs[14] = mk_s(1,1,0,1, 32'h0, 32'h7000, 32'h7004, 32'h0, 32'h0, 32'h0, 0, 4'd0, 5'd0);
    ve[14] = mk_e(1, 32'h0109_5021, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hA, 32'hB, 32'hC, 32'h0, 5'd8, 5'd9, 4'd14, 5'd31, 1, 0);

    reset = 1'b0;
    drive(z_s);
    #12;
    compare("reset", mk_e(0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8, 5'd0, 5'd0, 4'd0, 5'd0, 0, 0));
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      apply($sformatf("vec%0d", i), vs[i], ve[i]);
    end

    // Asynchronous reset in the middle of a hold
    apply("arst_load", mk_s(0,0,0,1, 32'h0109_5021, 32'h3060, 32'h3064, 32'h11, 32'h22, 32'h5021, 0, 4'd3, 5'd10),
          mk_e(1, 32'h0109_5021, 32'h3060, 32'h3064, 32'h11, 32'h22, 32'h5021, 32'h3068, 5'd8, 5'd9, 4'd3, 5'd10, 0, 0));
    @(negedge clk);
    drive(hold_s);
    #2;
    reset = 1'b0;
    #1;
    compare("arst_clear", mk_e(0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8, 5'd0, 5'd0, 4'd0, 5'd0, 0, 0));
    drive(mk_s(0,0,0,1, 32'h00A4_3020, 32'h3070, 32'h3074, 32'h33, 32'h44, 32'h3020, 1, 4'd2, 5'd6));
    sb_q.push_back(mk_e(1, 32'h00A4_3020, 32'h3070, 32'h3074, 32'h33, 32'h44, 32'h3020, 32'h3078, 5'd5, 5'd4, 4'd2, 5'd6, 1, 0));
    reset = 1'b1;
    score_edge("arst_resume");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
